am_audio_conditioner: RTL
=========================

// Module: am_audio_conditioner
// PURPOSE
// Sits directly downstream of the AM envelope demodulator. Takes its irregular-rate, carrier-locked envelope samples
// and removes the carrier-level DC with a leaky integrator. Re-times the result onto a fixed audio sample clock
// (zero-order hold) with a valid/ready output. Mutes on carrier loss and counts output overruns.
// PARAMETERS
// ENV_WIDTH    16  width of unsigned envelope input; audio output is ENV_WIDTH+1 signed
// SHIFT        10  DC tracker time constant, 2^SHIFT envelope samples
// STALE_TICKS  64  audio ticks with no env_valid before muting (>=1)
// PORTS
// clk            in   1             clock
// reset          in   1             synchronous, active-high
// env_in         in   ENV_WIDTH     envelope magnitude, treated as unsigned
// env_valid      in   1             env_in qualifier, single-cycle, any rate
// tick_div       in   32            clk cycles per audio sample; 0 and 1 both mean every cycle
// audio_out      out  ENV_WIDTH+1   signed DC-free audio sample
// audio_valid    out  1             audio_out valid; held until accepted
// audio_ready    in   1             consumer accepts when audio_valid && audio_ready
// muted          out  1             1 = MUTED state
// overrun_count  out  16            samples replaced before acceptance, saturates at 16'hFFFF
// BEHAVIOUR
// Reset values: audio_out=0, audio_valid=0, muted=1, overrun_count=0. Internal: dc_acc=0, held=0, tick_cnt=0, stale_cnt=0.
// Tick generator: tick_cnt counts 0..max(tick_div,1)-1.
// - tick asserts in the cycle tick_cnt >= max(tick_div,1)-1; tick_cnt then wraps to 0.
// - A live decrease of tick_div therefore ticks immediately.
// DC tracker: dc_acc is unsigned, ENV_WIDTH+SHIFT bits; dc = dc_acc >> SHIFT.
// FSM MUTED: held forced to 0.
// - On env_valid: dc_acc <= env_in<<SHIFT (preload, no thump), held <= 0, stale_cnt <= 0, go ACTIVE.
// FSM ACTIVE, on env_valid:
// - held <= env_in - dc, using dc before update; always fits ENV_WIDTH+1 signed, no saturation.
// - dc_acc <= dc_acc + env_in - dc.
// - stale_cnt <= 0.
// FSM ACTIVE, on tick without env_valid:
// - If stale_cnt == STALE_TICKS-1: go MUTED, held <= 0, stale_cnt <= 0.
// - Otherwise stale_cnt++.
// - env_valid in the same cycle as a tick wins: stale_cnt clears, no mute.
// muted is registered and equals (state==MUTED).
// Output stage, on tick:
// - audio_out <= held, sampling the value at the start of the cycle, so a same-cycle env_valid update appears at the next tick.
// - audio_valid <= 1.
// - If audio_valid && !audio_ready in that cycle, overrun_count++ (saturating); the pending sample is overwritten.
// Without tick: audio_valid <= 0 when audio_valid && audio_ready.
// Tick and acceptance in the same cycle: the new sample loads, audio_valid stays 1, no overrun.
// Latency: env_valid at cycle n -> held valid at n+1 -> audio_out/audio_valid at cycle t+1, where t is the first tick >= n+1.
// Reset mid-operation: all state returns to reset values next cycle; any pending audio sample is discarded.
// TESTING
// 1 SHIFT=2, tick_div=4, env 1000 repeated every 3 clk -> muted falls after the first env sample; every audio_out=0.
// 2 SHIFT=2, env 1000 then 1200,1200,1200 -> held sequence 0,200,150,113; dc_acc 4000,4200,4350,4463.
// 3 STALE_TICKS=4, env_valid stops -> muted=1 exactly 4 ticks after the last env tick; subsequent audio_out=0.
// 4 audio_ready=0 across 3 ticks -> audio_valid stays 1, overrun_count=2, audio_out=newest held; ready=1 -> valid drops next cycle.
// 5 env_valid coincident with the tick at stale_cnt=STALE_TICKS-1 -> no mute; that tick emits the old held value.
// 6 reset pulsed while ACTIVE with audio_valid=1 -> next cycle audio_valid=0, muted=1, overrun_count=0, tick_cnt restarts.

Source files
------------

// File: rtl/am_audio_conditioner_if.sv
// Envelope-in / audio-out bundle for the AM audio conditioner.
// The slave modport is the conditioner itself; the master modport is whoever
// feeds envelope samples, sets the audio rate and consumes audio samples.
interface am_audio_conditioner_if #(
    parameter int ENV_WIDTH = 16
);
    logic [ENV_WIDTH-1:0]      env_in;
    logic                      env_valid;
    logic [31:0]               tick_div;
    logic signed [ENV_WIDTH:0] audio_out;
    logic                      audio_valid;
    logic                      audio_ready;
    logic                      muted;
    logic [15:0]               overrun_count;

    modport master (
        output env_in,
        output env_valid,
        output tick_div,
        output audio_ready,
        input  audio_out,
        input  audio_valid,
        input  muted,
        input  overrun_count
    );

    modport slave (
        input  env_in,
        input  env_valid,
        input  tick_div,
        input  audio_ready,
        output audio_out,
        output audio_valid,
        output muted,
        output overrun_count
    );
endinterface

// File: rtl/am_audio_conditioner.sv
// AM audio conditioner: removes the carrier DC from demodulated envelope
// samples with a leaky integrator, re-times the result onto a fixed audio
// tick as a zero-order hold, mutes after carrier loss and counts overruns.
module am_audio_conditioner #(
    parameter int ENV_WIDTH   = 16,
    parameter int SHIFT       = 10,
    parameter int STALE_TICKS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    am_audio_conditioner_if.slave bus
);

    localparam int ACC_W   = ENV_WIDTH + SHIFT;
    localparam int STALE_W = (STALE_TICKS > 1) ? $clog2(STALE_TICKS) : 1;
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_TICKS - 1);

    typedef enum logic {
        MUTED  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [ACC_W-1:0]          dc_acc;
    logic [ACC_W-1:0]          dc_acc_next;
    logic signed [ENV_WIDTH:0] held;
    logic signed [ENV_WIDTH:0] held_next;
    logic [STALE_W-1:0]        stale_cnt;
    logic [STALE_W-1:0]        stale_next;
    logic [31:0]               tick_cnt;
    logic [31:0]               tick_last;
    logic                      tick;
    logic [ENV_WIDTH-1:0]      dc;
    logic signed [ENV_WIDTH:0] diff;

    logic signed [ENV_WIDTH:0] audio_reg;
    logic                      valid_reg;
    logic [15:0]               overrun_reg;

    // A divider of 0 or 1 both mean a tick every clock; using >= lets a live
    // decrease of the divider tick straight away instead of waiting for a wrap.
    assign tick_last = (bus.tick_div > 32'd1) ? (bus.tick_div - 32'd1) : 32'd0;
    assign tick      = (tick_cnt >= tick_last);

    // The tracked carrier level and the envelope's deviation from it always fit
    // ENV_WIDTH+1 signed bits because both operands are ENV_WIDTH unsigned.
    assign dc   = ENV_WIDTH'(dc_acc >> SHIFT);
    assign diff = $signed({1'b0, bus.env_in}) - $signed({1'b0, dc});

    // Free-running audio sample timebase.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    // Mute/active state register together with the DC tracker, held sample and stale counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MUTED;
            dc_acc    <= '0;
            held      <= '0;
            stale_cnt <= '0;
        end else begin
            state     <= state_next;
            dc_acc    <= dc_acc_next;
            held      <= held_next;
            stale_cnt <= stale_next;
        end
    end

    // Next-state logic: preload the tracker on carrier acquisition so the first
    // sample produces no thump, integrate while active, and mute after a run
    // of audio ticks with no envelope sample.
    always_comb begin
        state_next  = state;
        dc_acc_next = dc_acc;
        held_next   = held;
        stale_next  = stale_cnt;
        case (state)
            MUTED: begin
                held_next = '0;
                if (bus.env_valid) begin
                    dc_acc_next = ACC_W'(bus.env_in) << SHIFT;
                    stale_next  = '0;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.env_valid) begin
                    held_next   = diff;
                    dc_acc_next = dc_acc + ACC_W'(bus.env_in) - ACC_W'(dc);
                    stale_next  = '0;
                end else if (tick) begin
                    if (stale_cnt == STALE_LAST) begin
                        held_next  = '0;
                        stale_next = '0;
                        state_next = MUTED;
                    end else begin
                        stale_next = stale_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = MUTED;
            end
        endcase
    end

    // Zero-order-hold output: each tick publishes the held sample, replacing
    // any unaccepted one and counting that loss; acceptance clears valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_reg   <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= '0;
        end else if (tick) begin
            audio_reg <= held;
            valid_reg <= 1'b1;
            if (valid_reg && !bus.audio_ready && (overrun_reg != 16'hFFFF)) begin
                overrun_reg <= overrun_reg + 16'd1;
            end
        end else if (valid_reg && bus.audio_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.audio_out     = audio_reg;
    assign bus.audio_valid   = valid_reg;
    assign bus.overrun_count = overrun_reg;
    assign bus.muted         = (state == MUTED);

endmodule
